// File: rtl/vending_controller_pkg.sv
// Shared sizes, coin/price tables and controller state type for the vending machine.
package vending_machine_def;
  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 12;

  typedef logic [kTotalBits-1:0] amount_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DISPENSE,
    ST_RETURN
  } state_t;

  // Coin indices are ordered by ascending value; change selection depends on it.
  function automatic amount_t coin_value(input int idx);
    case (idx)
      0:       coin_value = amount_t'(100);
      1:       coin_value = amount_t'(500);
      2:       coin_value = amount_t'(1000);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic amount_t item_price(input int idx);
    case (idx)
      0:       item_price = amount_t'(400);
      1:       item_price = amount_t'(500);
      2:       item_price = amount_t'(1000);
      3:       item_price = amount_t'(2000);
      default: item_price = '0;
    endcase
  endfunction

  function automatic amount_t coin_mask_value(input logic [kNumCoins-1:0] mask);
    coin_mask_value = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (mask[k]) coin_mask_value = coin_mask_value | coin_value(k);
    end
  endfunction

  function automatic amount_t item_mask_price(input logic [kNumItems-1:0] mask);
    item_mask_price = '0;
    for (int k = 0; k < kNumItems; k++) begin
      if (mask[k]) item_mask_price = item_mask_price | item_price(k);
    end
  endfunction
endpackage

// File: rtl/vending_controller_if.sv
// User-facing coin/selection/return signals of the vending controller.
interface vending_controller_if;
  import vending_machine_def::*;

  logic [kNumCoins-1:0]  i_input_coin;
  logic [kNumItems-1:0]  i_select_item;
  logic                  i_trigger_return;
  logic [kNumItems-1:0]  o_available_item;
  logic [kNumItems-1:0]  o_output_item;
  logic [kNumCoins-1:0]  o_return_coin;
  logic [kTotalBits-1:0] current_total;
  logic                  o_busy;

  modport master (
    output i_input_coin, i_select_item, i_trigger_return,
    input  o_available_item, o_output_item, o_return_coin, current_total, o_busy
  );

  modport slave (
    input  i_input_coin, i_select_item, i_trigger_return,
    output o_available_item, o_output_item, o_return_coin, current_total, o_busy
  );
endinterface

// File: rtl/vending_controller_balance.sv
// Balance register: holds the customer credit, next value supplied by the controller FSM.
module balance_register
  import vending_machine_def::*;
(
  input  logic    clk,
  input  logic    reset,
  input  amount_t i_next,
  output amount_t o_value
);
  amount_t r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else begin
      r_value <= i_next;
    end
  end

  assign o_value = r_value;
endmodule

// File: rtl/vending_controller.sv
// Vending controller: accumulates coins, dispenses affordable items, returns change
// greedily on request or after an inactivity timeout.
module vending_controller
  import vending_machine_def::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                clk,
  input  logic                reset,
  vending_controller_if.slave io_bus
);
  localparam int kCntBits = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [kCntBits-1:0] kCntReload = kCntBits'(TIMEOUT_CYCLES);

  state_t               r_state, w_state_next;
  logic [kCntBits-1:0]  r_count, w_count_next;
  logic [kNumItems-1:0] r_sel, w_sel_next;
  amount_t              w_total, w_total_next;

  logic                  w_coin_ok, w_sel_ok;
  logic [kTotalBits:0]   w_coin_sum;
  amount_t               w_sel_price, w_disp_price, w_disp_left;
  amount_t               w_change_value, w_ret_left;
  logic [kNumCoins-1:0]  w_change;
  logic [kNumItems-1:0]  w_avail;

  // Greedy change: the largest coin that does not exceed the balance.
  function automatic logic [kNumCoins-1:0] pick_change(input amount_t bal);
    pick_change = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (bal >= coin_value(k)) pick_change = kNumCoins'(1) << k;
    end
  endfunction

  balance_register u_balance (
    .clk     (clk),
    .reset   (reset),
    .i_next  (w_total_next),
    .o_value (w_total)
  );

  // A coin that would carry out of the balance width is rejected outright.
  assign w_coin_sum     = {1'b0, w_total} + {1'b0, coin_mask_value(io_bus.i_input_coin)};
  assign w_coin_ok      = $onehot(io_bus.i_input_coin) && !w_coin_sum[kTotalBits];
  assign w_sel_price    = item_mask_price(io_bus.i_select_item);
  assign w_sel_ok       = $onehot(io_bus.i_select_item) && (w_total >= w_sel_price);
  assign w_disp_price   = item_mask_price(r_sel);
  assign w_disp_left    = w_total - w_disp_price;
  assign w_change       = pick_change(w_total);
  assign w_change_value = coin_mask_value(w_change);
  assign w_ret_left     = w_total - w_change_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= kCntReload;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sel   <= w_sel_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_sel_next   = r_sel;
    w_total_next = w_total;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_ok) begin
          w_total_next = w_coin_sum[kTotalBits-1:0];
          w_count_next = kCntReload;
          w_state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // A return request wins over any coin or selection in the same cycle.
        if (io_bus.i_trigger_return) begin
          w_state_next = ST_RETURN;
        end else if (w_coin_ok || w_sel_ok) begin
          if (w_coin_ok) begin
            w_total_next = w_coin_sum[kTotalBits-1:0];
            w_count_next = kCntReload;
          end
          if (w_sel_ok) begin
            w_sel_next   = io_bus.i_select_item;
            w_state_next = ST_DISPENSE;
          end
        end else if (r_count <= kCntBits'(1)) begin
          w_count_next = '0;
          w_state_next = ST_RETURN;
        end else begin
          w_count_next = r_count - kCntBits'(1);
        end
      end
      ST_DISPENSE: begin
        w_total_next = w_disp_left;
        w_count_next = kCntReload;
        w_state_next = (w_disp_left != '0) ? ST_ACCUM : ST_IDLE;
      end
      ST_RETURN: begin
        w_total_next = w_ret_left;
        if (w_ret_left == '0) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < kNumItems; gi++) begin : g_avail
      assign w_avail[gi] = ((r_state == ST_IDLE) || (r_state == ST_ACCUM)) &&
                           (w_total >= item_price(gi));
    end
  endgenerate

  // Pulse outputs decode registered state only, so inputs never reach outputs combinationally.
  assign io_bus.o_available_item = w_avail;
  assign io_bus.o_output_item    = (r_state == ST_DISPENSE) ? r_sel : '0;
  assign io_bus.o_return_coin    = (r_state == ST_RETURN) ? w_change : '0;
  assign io_bus.current_total    = w_total;
  assign io_bus.o_busy           = (r_state == ST_DISPENSE) || (r_state == ST_RETURN);
endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural credit/change model.
module tb_vending_controller;
  localparam int TIMEOUT = 100;
  localparam int MAX_BAL = 4095;
  localparam int M_IDLE  = 0;
  localparam int M_ACCUM = 1;
  localparam int M_DISP  = 2;
  localparam int M_RET   = 3;

  logic clk;
  logic rst;
  vending_controller_if bus();

  vending_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int coin_v[3]  = '{100, 500, 1000};
  int price_v[4] = '{400, 500, 1000, 2000};

  int n_total = 0;
  int n_bad   = 0;
  bit check_en = 1'b0;

  // Model state: credit, activity mode, idle countdown, item being vended, change still owed.
  int m_bal  = 0;
  int m_mode = M_IDLE;
  int m_cnt  = TIMEOUT;
  int m_item = 0;
  int m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_return();
    int rem;
    rem = m_bal;
    m_q.delete();
    for (int k = 2; k >= 0; k--) begin
      while (rem >= coin_v[k]) begin
        m_q.push_back(k);
        rem -= coin_v[k];
      end
    end
    m_mode = M_RET;
  endtask

  task automatic model_step(input logic [2:0] c, input logic [3:0] s, input logic t,
                            input logic r);
    bit coin_ok;
    bit sel_ok;
    int cv;
    int si;
    if (r) begin
      m_mode = M_IDLE;
      m_bal  = 0;
      m_cnt  = TIMEOUT;
      m_q.delete();
      return;
    end
    coin_ok = 1'b0;
    sel_ok  = 1'b0;
    cv = 0;
    si = 0;
    if ($countones(c) == 1) begin
      for (int k = 0; k < 3; k++) if (c[k]) cv = coin_v[k];
      coin_ok = (m_bal + cv <= MAX_BAL);
    end
    if ($countones(s) == 1) begin
      for (int k = 0; k < 4; k++) if (s[k]) si = k;
      sel_ok = (m_bal >= price_v[si]);
    end
    case (m_mode)
      M_IDLE: begin
        if (coin_ok) begin
          m_bal += cv;
          m_cnt = TIMEOUT;
          m_mode = M_ACCUM;
        end
      end
      M_ACCUM: begin
        if (t) begin
          start_return();
        end else if (coin_ok || sel_ok) begin
          if (coin_ok) begin
            m_bal += cv;
            m_cnt = TIMEOUT;
          end
          if (sel_ok) begin
            m_item = si;
            m_mode = M_DISP;
          end
        end else begin
          m_cnt--;
          if (m_cnt == 0) start_return();
        end
      end
      M_DISP: begin
        m_bal -= price_v[m_item];
        m_cnt = TIMEOUT;
        m_mode = (m_bal > 0) ? M_ACCUM : M_IDLE;
      end
      default: begin
        m_bal -= coin_v[m_q.pop_front()];
        if (m_q.size() == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [3:0] e_avail;
    logic [3:0] e_out;
    logic [2:0] e_ret;
    logic       e_busy;
    if (check_en) begin
      e_avail = '0;
      for (int k = 0; k < 4; k++) begin
        if (m_mode <= M_ACCUM && m_bal >= price_v[k]) e_avail[k] = 1'b1;
      end
      e_out  = (m_mode == M_DISP) ? 4'(1 << m_item) : 4'b0;
      e_ret  = (m_mode == M_RET && m_q.size() > 0) ? 3'(1 << m_q[0]) : 3'b0;
      e_busy = (m_mode == M_DISP) || (m_mode == M_RET);
      chk("cmp_total", 32'(bus.current_total), 32'(m_bal));
      chk("cmp_avail", 32'(bus.o_available_item), 32'(e_avail));
      chk("cmp_out", 32'(bus.o_output_item), 32'(e_out));
      chk("cmp_ret", 32'(bus.o_return_coin), 32'(e_ret));
      chk("cmp_busy", 32'(bus.o_busy), 32'(e_busy));
      if (bus.o_output_item != 4'b0)
        $display("txn t=%0t dispense item=%b total=%0d", $time, bus.o_output_item, bus.current_total);
      if (bus.o_return_coin != 3'b0)
        $display("txn t=%0t return coin=%b total=%0d", $time, bus.o_return_coin, bus.current_total);
    end
  end

  task automatic cycle(input logic [2:0] c, input logic [3:0] s, input logic t, input logic r);
    bus.i_input_coin     = c;
    bus.i_select_item    = s;
    bus.i_trigger_return = t;
    rst                  = r;
    @(posedge clk);
    model_step(c, s, t, r);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(3'b000, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle(input bit quiet);
    logic [2:0] c;
    logic [3:0] s;
    logic t;
    logic r;
    int p;
    c = '0;
    s = '0;
    p = int'($urandom_range(999));
    if (p < (quiet ? 15 : 300)) c = 3'(1 << $urandom_range(2));
    else if (p < (quiet ? 20 : 340)) c = 3'($urandom);
    p = int'($urandom_range(999));
    if (p < (quiet ? 10 : 250)) s = 4'(1 << $urandom_range(3));
    else if (p < (quiet ? 12 : 290)) s = 4'($urandom);
    t = (int'($urandom_range(999)) < (quiet ? 2 : 25));
    r = (int'($urandom_range(999)) < (quiet ? 0 : 4));
    cycle(c, s, t, r);
  endtask

  localparam logic [2:0] C100  = 3'b001;
  localparam logic [2:0] C500  = 3'b010;
  localparam logic [2:0] C1000 = 3'b100;

  initial begin
    bus.i_input_coin     = '0;
    bus.i_select_item    = '0;
    bus.i_trigger_return = 1'b0;
    rst                  = 1'b1;
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    check_en = 1'b1;
    chk("reset_total", 32'(bus.current_total), 32'd0);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_avail", 32'(bus.o_available_item), 32'd0);

    // Coin accumulation and availability.
    cycle(C500, 4'b0000, 1'b0, 1'b0);
    chk("ins_500", 32'(bus.current_total), 32'd500);
    cycle(C100, 4'b0000, 1'b0, 1'b0);
    chk("ins_600", 32'(bus.current_total), 32'd600);
    chk("avail_600", 32'(bus.o_available_item), 32'b0011);

    // Dispense item 0 from 600.
    cycle(3'b000, 4'b0001, 1'b0, 1'b0);
    chk("disp_out", 32'(bus.o_output_item), 32'b0001);
    chk("disp_busy", 32'(bus.o_busy), 32'd1);
    idle();
    chk("disp_total", 32'(bus.current_total), 32'd200);
    chk("disp_out_end", 32'(bus.o_output_item), 32'd0);

    // Return request in IDLE does nothing.
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    chk("trig_idle_busy", 32'(bus.o_busy), 32'd0);

    // Change for 1600: 1000, 500, 100.
    cycle(C1000, 4'b0000, 1'b0, 1'b0);
    cycle(C500, 4'b0000, 1'b0, 1'b0);
    cycle(C100, 4'b0000, 1'b0, 1'b0);
    chk("bal_1600", 32'(bus.current_total), 32'd1600);
    chk("avail_1600", 32'(bus.o_available_item), 32'b0111);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    chk("ret_1000", 32'(bus.o_return_coin), 32'b100);
    idle();
    chk("ret_500", 32'(bus.o_return_coin), 32'b010);
    chk("ret_total_600", 32'(bus.current_total), 32'd600);
    idle();
    chk("ret_100", 32'(bus.o_return_coin), 32'b001);
    idle();
    chk("ret_done_total", 32'(bus.current_total), 32'd0);
    chk("ret_done_busy", 32'(bus.o_busy), 32'd0);

    // Inactivity timeout after a single 100 coin.
    cycle(C100, 4'b0000, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) idle();
    chk("timeout_before", 32'(bus.o_busy), 32'd0);
    idle();
    chk("timeout_busy", 32'(bus.o_busy), 32'd1);
    chk("timeout_coin", 32'(bus.o_return_coin), 32'b001);
    idle();
    chk("timeout_total", 32'(bus.current_total), 32'd0);

    // Unaffordable selection: no vend and the countdown keeps running.
    repeat (3) cycle(C100, 4'b0000, 1'b0, 1'b0);
    cycle(3'b000, 4'b1000, 1'b0, 1'b0);
    chk("unaff_out", 32'(bus.o_output_item), 32'd0);
    chk("unaff_total", 32'(bus.current_total), 32'd300);
    repeat (TIMEOUT - 2) idle();
    chk("noreload_before", 32'(bus.o_busy), 32'd0);
    idle();
    chk("noreload_busy", 32'(bus.o_busy), 32'd1);
    repeat (3) idle();
    chk("noreload_total", 32'(bus.current_total), 32'd0);

    // Coin plus selection together; selection judged on the pre-coin balance.
    cycle(C500, 4'b0000, 1'b0, 1'b0);
    cycle(C100, 4'b0010, 1'b0, 1'b0);
    chk("same_out", 32'(bus.o_output_item), 32'b0010);
    chk("same_total", 32'(bus.current_total), 32'd600);
    cycle(C1000, 4'b0000, 1'b0, 1'b0);
    chk("disp_coin_ignored", 32'(bus.current_total), 32'd100);
    cycle(C500, 4'b0001, 1'b0, 1'b0);
    chk("precoin_out", 32'(bus.o_output_item), 32'd0);
    chk("precoin_total", 32'(bus.current_total), 32'd600);
    cycle(3'b011, 4'b0000, 1'b0, 1'b0);
    chk("multi_coin", 32'(bus.current_total), 32'd600);
    cycle(3'b000, 4'b0011, 1'b0, 1'b0);
    chk("multi_sel", 32'(bus.o_output_item), 32'd0);

    // Saturation: coins that would overflow 4095 are rejected.
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    repeat (4) cycle(C1000, 4'b0000, 1'b0, 1'b0);
    cycle(C500, 4'b0000, 1'b0, 1'b0);
    chk("sat_500", 32'(bus.current_total), 32'd4000);
    cycle(C100, 4'b0000, 1'b0, 1'b0);
    chk("sat_100", 32'(bus.current_total), 32'd4000);

    // Reset in the middle of a return discards the rest.
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    cycle(C1000, 4'b0000, 1'b0, 1'b0);
    cycle(C500, 4'b0000, 1'b0, 1'b0);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    chk("abort_first", 32'(bus.o_return_coin), 32'b100);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    chk("abort_total", 32'(bus.current_total), 32'd0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    idle();
    chk("abort_no_coin", 32'(bus.o_return_coin), 32'd0);

    // Randomized traffic, alternating busy and sparse phases so timeouts occur.
    for (int blk = 0; blk < 12; blk++) begin
      for (int i = 0; i < 300; i++) rand_cycle(blk % 3 == 2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100; idle cycles before automatic change return.
REQ-002 Port clk, input, 1; single clock, all state updates on its rising edge.
REQ-003 Port reset, input, 1; synchronous active-high reset, sampled at rising clk.
REQ-004 Port i_input_coin, input, kNumCoins; one-hot per cycle, coin inserted this cycle (values 100/500/1000).
REQ-005 Port i_select_item, input, kNumItems; one-hot per cycle, item requested this cycle (prices 400/500/1000/2000).
REQ-006 Port i_trigger_return, input, 1; user request to return all remaining balance.
REQ-007 Port o_available_item, output, kNumItems; bit k high when current_total >= price[k] and state is ACCUM or IDLE.
REQ-008 Port o_output_item, output, kNumItems; one-cycle pulse, item dispensed.
REQ-009 Port o_return_coin, output, kNumCoins; one-cycle pulse, one coin returned per cycle.
REQ-010 Port current_total, output, kTotalBits; registered balance.
REQ-011 Port o_busy, output, 1; high in DISPENSE and RETURN states.

Function
REQ-012 States: IDLE (balance 0), ACCUM (balance > 0), DISPENSE, RETURN.
REQ-013 IDLE -> ACCUM when a valid coin is inserted; balance += coin value, visible next cycle.
REQ-014 ACCUM: coin insert adds value and reloads timeout counter to TIMEOUT_CYCLES.
REQ-015 ACCUM: valid, affordable selection -> DISPENSE; unaffordable selection ignored, no output, no counter reload.
REQ-016 DISPENSE lasts exactly one cycle: o_output_item pulses the selected bit, balance -= price, counter reloads; next state ACCUM if balance > 0 else IDLE.
REQ-017 Coin and selection in same ACCUM cycle: coin added first, selection evaluated against pre-coin balance.
REQ-018 Inputs with more than one bit set SHALL be ignored entirely that cycle.
REQ-019 ACCUM -> RETURN on i_trigger_return or counter reaching 0; counter decrements once per ACCUM cycle with no accepted event.
REQ-020 RETURN: greedy largest-coin-first, one coin per cycle; o_return_coin pulses that coin, balance decremented same edge; -> IDLE when balance reaches 0.
REQ-021 Coins and selections during DISPENSE/RETURN SHALL be ignored (no balance change).
REQ-022 Balance saturates at 2^kTotalBits-1; coin that would overflow is rejected (not added).
REQ-023 i_trigger_return in IDLE has no effect.
REQ-024 All outputs are registered or decoded only from registered state; no combinational input-to-output path.

Reset
REQ-025 On reset: state IDLE, current_total 0, counter TIMEOUT_CYCLES, all pulse outputs 0, o_busy 0.
REQ-026 Reset mid-RETURN or mid-DISPENSE aborts immediately; unreturned balance is discarded.
REQ-027 Reset has priority over every other input in the same cycle.

Structure
REQ-028 kNumCoins, kNumItems, kTotalBits, coin values, item prices and state enum SHALL live in the shared vending_machine_def package/include.
REQ-029 Balance register update is delegated to sub-module balance_register (clk, reset, next value, current value); the FSM computes the next value.
REQ-030 Change-coin selection is a combinational function inside the controller, not a sub-module.

Verification
REQ-031 Reset, insert 500 then 100 -> current_total 500 then 600; o_available_item = 0011.
REQ-032 Balance 600, select item 0 (400) -> o_output_item 0001 one cycle, current_total 200, state ACCUM.
REQ-033 Balance 1600, i_trigger_return -> o_return_coin pulses 1000, 500, 100 on consecutive cycles, then IDLE with total 0.
REQ-034 Insert 100, no activity for TIMEOUT_CYCLES cycles -> RETURN entered on cycle 100, one 100-coin returned.
REQ-035 Balance 300, select item 3 (2000) -> no output, total unchanged, timeout not reloaded.
REQ-036 Assert reset during RETURN of balance 1500 -> next cycle total 0, IDLE, no further o_return_coin pulses.
